// File: rtl/sevenseg_pkg.sv
// ============================================================================
// Module : sevenseg_pkg
// Brief  : Seven-segment codes, decoded value markers and reader FSM states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sevenseg_pkg;

    // Segment codes, gfedcba order, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] VAL_BLANK   = 4'd12;
    localparam logic [3:0] VAL_INVALID = 4'd15;

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sevenseg_decode.sv
// ============================================================================
// Module : sevenseg_decode
// Brief  : Combinational segment pattern to 4-bit value decoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       invalid
);

    always_comb begin
        value   = VAL_INVALID;
        invalid = 1'b0;
        case (seg)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: value = VAL_BLANK;
            default: begin
                value   = VAL_INVALID;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sevenseg_reader.sv
// ============================================================================
// Module : sevenseg_reader
// Brief  : Synchronises, debounces and decodes a seven-segment bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sevenseg_reader
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,   // 1..15
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       seg_in,
    input  logic             clr,
    output logic [3:0]       value,
    output logic             blank,
    output logic             invalid,
    output logic             update,
    output logic [CNT_W-1:0] change_cnt,
    output logic             err_sticky
);

    localparam logic [3:0] C_STABLE = 4'(STABLE_CYCLES);

    logic [6:0] r_s1;
    logic [6:0] r_s2;
    logic [6:0] r_cand;
    logic [6:0] r_committed;
    logic [3:0] r_cnt;
    state_t     r_state;

    logic       w_change;
    logic [6:0] w_next_cand;
    logic [3:0] w_next_cnt;
    logic       w_counting;
    logic       w_reach;
    logic       w_commit;
    logic [3:0] w_dec_value;
    logic       w_dec_invalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= SEG_BLANK;
            r_s2 <= SEG_BLANK;
        end else begin
            r_s1 <= seg_in;
            r_s2 <= r_s1;
        end
    end

    assign w_change    = (r_s2 != r_cand);
    assign w_next_cand = w_change ? r_s2 : r_cand;
    assign w_next_cnt  = w_change ? 4'd1 :
                         ((r_cnt == 4'hF) ? 4'hF : r_cnt + 4'd1);
    assign w_counting  = w_change || (r_state == ST_SETTLE);
    assign w_reach     = w_counting && (w_next_cnt >= C_STABLE);
    assign w_commit    = w_reach && (w_next_cand != r_committed);

    // Decode the candidate as it will stand after this edge, so that a
    // single-cycle threshold can commit on the very edge that loads it.
    sevenseg_decode u_decode (
        .seg     (w_next_cand),
        .value   (w_dec_value),
        .invalid (w_dec_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOCKED;
            r_cand      <= SEG_BLANK;
            r_cnt       <= C_STABLE;
            r_committed <= SEG_BLANK;
            value       <= VAL_BLANK;
            blank       <= 1'b1;
            invalid     <= 1'b0;
            update      <= 1'b0;
            change_cnt  <= '0;
            err_sticky  <= 1'b0;
        end else begin
            update <= w_commit;
            r_cand <= w_next_cand;
            if (w_counting) begin
                r_cnt <= w_next_cnt;
            end

            if (w_reach) begin
                r_state <= ST_LOCKED;
            end else if (w_change) begin
                r_state <= ST_SETTLE;
            end

            if (w_commit) begin
                r_committed <= w_next_cand;
                value       <= w_dec_value;
                blank       <= (w_dec_value == VAL_BLANK);
                invalid     <= w_dec_invalid;
            end

            // Clear first, then count this edge's commit on top of it
            if (clr) begin
                change_cnt <= w_commit ? CNT_W'(1) : '0;
            end else if (w_commit) begin
                change_cnt <= change_cnt + CNT_W'(1);
            end

            if (w_commit && w_dec_invalid) begin
                err_sticky <= 1'b1;
            end else if (clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_reader.sv
// ============================================================================
// Module : tb_sevenseg_reader
// Brief  : Scoreboard bench for sevenseg_reader with default parameters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sevenseg_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic       clr = 1'b0;
    logic [3:0] value;
    logic       blank;
    logic       invalid;
    logic       update;
    logic [7:0] change_cnt;
    logic       err_sticky;

    sevenseg_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .clr        (clr),
        .value      (value),
        .blank      (blank),
        .invalid    (invalid),
        .update     (update),
        .change_cnt (change_cnt),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [6:0] DIGITS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        int         cyc;
        logic [3:0] value;
        logic       inv;
        logic       blank;
        logic [7:0] cnt;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic       exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_decode(input logic [6:0] s);
        for (int i = 0; i < 10; i++) begin
            if (DIGITS[i] == s) return {1'b0, 4'(i)};
        end
        if (s == 7'h00) return {1'b0, 4'd12};
        return {1'b1, 4'd15};
    endfunction

    // Expected commit lands six edges after the bus changes at a negedge
    task automatic push_commit(input logic [6:0] code, input bit with_clr);
        exp_t       e;
        logic [4:0] d;
        d       = model_decode(code);
        exp_cnt = with_clr ? 8'd1 : exp_cnt + 8'd1;
        if (d[4]) exp_err = 1'b1;
        e.cyc   = cyc + 6;
        e.value = d[3:0];
        e.inv   = d[4];
        e.blank = (code == 7'h00);
        e.cnt   = exp_cnt;
        e.err   = exp_err;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [6:0] code, input bit commits, input int hold,
                         input bit clr_on_commit);
        seg_in = code;
        if (commits) push_commit(code, clr_on_commit);
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (clr_on_commit && i == 5) clr = 1'b1;
            if (clr_on_commit && i == 6) clr = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (update) begin
                if (sb.size() == 0) begin
                    check("spurious_update", 32'(update), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("update_cycle", cyc, e.cyc);
                    check("value", 32'(value), 32'(e.value));
                    check("invalid", 32'(invalid), 32'(e.inv));
                    check("blank", 32'(blank), 32'(e.blank));
                    check("change_cnt", 32'(change_cnt), 32'(e.cnt));
                    check("err_sticky", 32'(err_sticky), 32'(e.err));
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                check("missing_update", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value"}, 32'(value), 32'd12);
        check({tag, "_blank"}, 32'(blank), 32'd1);
        check({tag, "_invalid"}, 32'(invalid), 32'd0);
        check({tag, "_update"}, 32'(update), 32'd0);
        check({tag, "_cnt"}, 32'(change_cnt), 32'd0);
        check({tag, "_err"}, 32'(err_sticky), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Blank bus must never commit
        drive(7'h00, 1'b0, 20, 1'b0);
        check("idle_value", 32'(value), 32'd12);
        check("idle_blank", 32'(blank), 32'd1);
        check("idle_cnt", 32'(change_cnt), 32'd0);

        drive(7'h5B, 1'b1, 26, 1'b0);
        check("hold_value", 32'(value), 32'd2);

        // Short glitch away and back must be ignored
        drive(7'h06, 1'b1, 10, 1'b0);
        drive(7'h7F, 1'b0, 3, 1'b0);
        drive(7'h06, 1'b0, 12, 1'b0);
        check("glitch_value", 32'(value), 32'd1);
        check("glitch_cnt", 32'(change_cnt), 32'(exp_cnt));

        drive(7'h49, 1'b1, 10, 1'b0);
        check("bad_err", 32'(err_sticky), 32'd1);
        drive(7'h3F, 1'b1, 10, 1'b0);
        check("good_invalid", 32'(invalid), 32'd0);
        check("good_err_held", 32'(err_sticky), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_cnt = 8'd0;
        exp_err = 1'b0;
        check("clr_err", 32'(err_sticky), 32'd0);
        check("clr_cnt", 32'(change_cnt), 32'd0);

        for (int i = 0; i < 256; i++) begin
            drive((i % 2 == 0) ? 7'h06 : 7'h5B, 1'b1, 8, 1'b0);
        end
        check("wrap_cnt", 32'(change_cnt), 32'd0);
        drive(7'h7F, 1'b1, 10, 1'b1);
        check("clr_commit_cnt", 32'(change_cnt), 32'd1);

        // Reset while settling on a new pattern
        drive(7'h6D, 1'b0, 3, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_cnt = 8'd0;
        exp_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(7'h6D, 1'b1, 12, 1'b0);
        check("post_rst_value", 32'(value), 32'd5);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
